// File: rtl/frame_scheduler_if.sv
// rtl/frame_scheduler_if.sv - frame_scheduler handshake bundle (scheduler = master, output/render side = slave)
interface frame_scheduler_if #(
  parameter int CNT_W = 16
);
  logic             enable;
  logic             new_frame;
  logic             frame_tick;
  logic             render_start;
  logic             render_done;
  logic             render_ack;
  logic             buf_sel_display;
  logic             buf_sel_render;
  logic             render_busy;
  logic [CNT_W-1:0] dropped_frames;
  logic             timeout;

  modport master (
    input  enable, new_frame, render_done,
    output frame_tick, render_start, render_ack, buf_sel_display, buf_sel_render,
           render_busy, dropped_frames, timeout
  );

  modport slave (
    output enable, new_frame, render_done,
    input  frame_tick, render_start, render_ack, buf_sel_display, buf_sel_render,
           render_busy, dropped_frames, timeout
  );
endinterface

// File: rtl/frame_scheduler.sv
// rtl/frame_scheduler.sv - per-frame tick/render/swap sequencer with overrun counter
// Optional render watchdog enabled by defining FRAME_SCHED_WATCHDOG_EN.
module frame_scheduler #(
  parameter int CNT_W = 16
`ifdef FRAME_SCHED_WATCHDOG_EN
  , parameter int TIMEOUT_FRAMES = 4
`endif
) (
  input  logic              Clk,
  input  logic              Reset_n,
  frame_scheduler_if.master bus
);

  typedef enum logic [2:0] {
    IDLE, TICK, START, RENDER, WAIT_VB, SWAP, ACKW
  } state_t;

  state_t           state, next_state;
  logic             frame_tick_q, render_start_q, render_ack_q, busy_q;
  logic             buf_disp_q, buf_rend_q;
  logic             frame_tick_d, render_start_d, render_ack_d, busy_d, buf_disp_d;
  logic [CNT_W-1:0] dropped_q;
  logic             drop_evt;
  logic             wd_fire;

  // A frame start that arrives while the render is still drawing is an overrun.
  assign drop_evt = (state == RENDER) && bus.new_frame && !bus.render_done;

`ifdef FRAME_SCHED_WATCHDOG_EN
  localparam int WD_W = $clog2(TIMEOUT_FRAMES + 1);

  logic [WD_W-1:0] wd_cnt;
  logic            timeout_q;

  assign wd_fire = drop_evt && (wd_cnt == WD_W'(TIMEOUT_FRAMES - 1));

  // Held at zero outside RENDER so every render starts with a fresh frame budget.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      wd_cnt    <= '0;
      timeout_q <= 1'b0;
    end else begin
      if (state != RENDER) begin
        wd_cnt <= '0;
      end else if (drop_evt) begin
        wd_cnt <= wd_cnt + 1'b1;
      end
      if (wd_fire) begin
        timeout_q <= 1'b1;
      end
    end
  end

  assign bus.timeout = timeout_q;
`else
  assign wd_fire     = 1'b0;
  assign bus.timeout = 1'b0;
`endif

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state          <= IDLE;
      frame_tick_q   <= 1'b0;
      render_start_q <= 1'b0;
      render_ack_q   <= 1'b0;
      busy_q         <= 1'b0;
      buf_disp_q     <= 1'b0;
      buf_rend_q     <= 1'b1;
    end else begin
      state          <= next_state;
      frame_tick_q   <= frame_tick_d;
      render_start_q <= render_start_d;
      render_ack_q   <= render_ack_d;
      busy_q         <= busy_d;
      buf_disp_q     <= buf_disp_d;
      buf_rend_q     <= ~buf_disp_d;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (bus.new_frame && bus.enable) next_state = TICK;
      TICK:    next_state = START;
      START:   next_state = RENDER;
      RENDER: begin
        if (bus.render_done && bus.new_frame) begin
          next_state = SWAP;
        end else if (bus.render_done) begin
          next_state = WAIT_VB;
        end else if (wd_fire) begin
          next_state = IDLE;
        end
      end
      WAIT_VB: if (bus.new_frame) next_state = SWAP;
      SWAP:    next_state = ACKW;
      ACKW:    if (!bus.render_done) next_state = bus.enable ? TICK : IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Outputs are decoded from the upcoming state so they land in flops aligned with it.
  always_comb begin
    frame_tick_d   = (next_state == TICK);
    render_start_d = (next_state == START);
    render_ack_d   = (next_state == SWAP) || wd_fire;
    busy_d         = (next_state inside {TICK, START, RENDER, WAIT_VB});
    buf_disp_d     = (next_state == SWAP) ? ~buf_disp_q : buf_disp_q;
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      dropped_q <= '0;
    end else if (drop_evt && (dropped_q != {CNT_W{1'b1}})) begin
      dropped_q <= dropped_q + 1'b1;
    end
  end

  assign bus.frame_tick      = frame_tick_q;
  assign bus.render_start    = render_start_q;
  assign bus.render_ack      = render_ack_q;
  assign bus.render_busy     = busy_q;
  assign bus.buf_sel_display = buf_disp_q;
  assign bus.buf_sel_render  = buf_rend_q;
  assign bus.dropped_frames  = dropped_q;

endmodule

// File: tb/tb_frame_scheduler.sv
// tb/tb_frame_scheduler.sv - self-checking bench for frame_scheduler, FRAME_SCHED_WATCHDOG_EN aware
module tb_frame_scheduler;
  localparam int CW   = 3;
  localparam int MAXD = (1 << CW) - 1;
  localparam int MAXC = 4000;
`ifdef FRAME_SCHED_WATCHDOG_EN
  localparam int TO      = 4;
  localparam int DUR_MAX = 40;
`else
  localparam int DUR_MAX = 160;
`endif

  logic Clk = 1'b0;
  logic Reset_n;
  int   checks = 0;
  int   errors = 0;

  frame_scheduler_if #(.CNT_W(CW)) bus ();

`ifdef FRAME_SCHED_WATCHDOG_EN
  frame_scheduler #(.CNT_W(CW), .TIMEOUT_FRAMES(TO)) dut (.Clk(Clk), .Reset_n(Reset_n), .bus(bus));
`else
  frame_scheduler #(.CNT_W(CW)) dut (.Clk(Clk), .Reset_n(Reset_n), .bus(bus));
`endif

  always #5 Clk = ~Clk;

  // Planned stimulus and expected outputs per cycle for the randomized run.
  bit nf_b[MAXC];
  bit dn_b[MAXC];
  bit en_b[MAXC];
  bit e_tick[MAXC];
  bit e_start[MAXC];
  bit e_ack[MAXC];
  bit e_busy[MAXC];
  bit e_disp[MAXC];
  bit drop_ev[MAXC];
  bit tog[MAXC];
  int e_drop[MAXC];

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic do_reset();
    Reset_n         = 1'b0;
    bus.enable      = 1'b0;
    bus.new_frame   = 1'b0;
    bus.render_done = 1'b0;
    tick();
    tick();
    Reset_n    = 1'b1;
    bus.enable = 1'b1;
  endtask

  task automatic pulse_nf();
    bus.new_frame = 1'b1;
    tick();
    bus.new_frame = 1'b0;
  endtask

  task automatic start_render();
    pulse_nf();
    tick();
    tick();
  endtask

  task automatic test_reset();
    Reset_n         = 1'b0;
    bus.enable      = 1'b1;
    bus.new_frame   = 1'b1;
    bus.render_done = 1'b1;
    tick();
    tick();
    checks++;
    if ({bus.frame_tick, bus.render_start, bus.render_ack, bus.render_busy,
         bus.buf_sel_display, bus.buf_sel_render, bus.timeout} !== 7'b0000010 ||
        bus.dropped_frames !== CW'(0)) begin
      errors++;
      $display("FAIL reset_state: got %b/%0d expected 0000010/0",
               {bus.frame_tick, bus.render_start, bus.render_ack, bus.render_busy,
                bus.buf_sel_display, bus.buf_sel_render, bus.timeout}, bus.dropped_frames);
    end
    Reset_n         = 1'b1;
    bus.new_frame   = 1'b0;
    bus.render_done = 1'b0;
    tick();
    checks++;
    if (bus.render_busy !== 1'b0 || bus.frame_tick !== 1'b0) begin
      errors++;
      $display("FAIL reset_release_idle: busy=%b tick=%b expected 0 0", bus.render_busy, bus.frame_tick);
    end
  endtask

  task automatic test_first_frame();
    do_reset();
    repeat ($urandom_range(3, 9)) begin
      tick();
      checks++;
      if (bus.frame_tick !== 1'b0 || bus.render_busy !== 1'b0) begin
        errors++;
        $display("FAIL idle_quiet: tick=%b busy=%b expected 0 0", bus.frame_tick, bus.render_busy);
      end
    end
    pulse_nf();
    checks++;
    if ({bus.frame_tick, bus.render_start, bus.render_busy} !== 3'b101) begin
      errors++;
      $display("FAIL tick_latency: tick/start/busy=%b expected 101",
               {bus.frame_tick, bus.render_start, bus.render_busy});
    end
    tick();
    checks++;
    if ({bus.frame_tick, bus.render_start} !== 2'b01) begin
      errors++;
      $display("FAIL start_latency: tick/start=%b expected 01", {bus.frame_tick, bus.render_start});
    end
    tick();
    checks++;
    if ({bus.render_start, bus.render_busy, bus.buf_sel_display, bus.buf_sel_render} !== 4'b0101) begin
      errors++;
      $display("FAIL render_bufs: start/busy/disp/rend=%b expected 0101",
               {bus.render_start, bus.render_busy, bus.buf_sel_display, bus.buf_sel_render});
    end
    repeat (20) tick();
    bus.render_done = 1'b1;
    repeat (30) tick();
    checks++;
    if ({bus.render_ack, bus.render_busy, bus.buf_sel_display} !== 3'b010) begin
      errors++;
      $display("FAIL wait_vblank: ack/busy/disp=%b expected 010",
               {bus.render_ack, bus.render_busy, bus.buf_sel_display});
    end
    pulse_nf();
    checks++;
    if ({bus.render_ack, bus.buf_sel_display, bus.buf_sel_render, bus.render_busy} !== 4'b1100) begin
      errors++;
      $display("FAIL swap_ack: ack/disp/rend/busy=%b expected 1100",
               {bus.render_ack, bus.buf_sel_display, bus.buf_sel_render, bus.render_busy});
    end
    tick();
    bus.render_done = 1'b0;
    checks++;
    if ({bus.render_ack, bus.frame_tick, bus.buf_sel_display} !== 3'b001) begin
      errors++;
      $display("FAIL ack_single: ack/tick/disp=%b expected 001",
               {bus.render_ack, bus.frame_tick, bus.buf_sel_display});
    end
    tick();
    checks++;
    if (bus.frame_tick !== 1'b1) begin
      errors++;
      $display("FAIL b2b_tick: got %b expected 1", bus.frame_tick);
    end
    tick();
    checks++;
    if (bus.render_start !== 1'b1 || bus.dropped_frames !== CW'(0)) begin
      errors++;
      $display("FAIL b2b_start: start=%b drops=%0d expected 1 0", bus.render_start, bus.dropped_frames);
    end
  endtask

  task automatic test_overrun();
    do_reset();
    start_render();
    for (int k = 1; k <= 3; k++) begin
      repeat ($urandom_range(2, 15)) tick();
      pulse_nf();
      checks++;
      if (bus.dropped_frames !== CW'(k) || bus.render_ack !== 1'b0) begin
        errors++;
        $display("FAIL overrun_count: drops=%0d ack=%b expected %0d 0", bus.dropped_frames, bus.render_ack, k);
      end
    end
    bus.render_done = 1'b1;
    repeat ($urandom_range(1, 10)) tick();
    checks++;
    if ({bus.render_busy, bus.render_ack, bus.buf_sel_display} !== 3'b100) begin
      errors++;
      $display("FAIL overrun_wait: busy/ack/disp=%b expected 100",
               {bus.render_busy, bus.render_ack, bus.buf_sel_display});
    end
    pulse_nf();
    checks++;
    if ({bus.render_ack, bus.buf_sel_display} !== 2'b11 || bus.dropped_frames !== CW'(3)) begin
      errors++;
      $display("FAIL overrun_swap: ack/disp=%b drops=%0d expected 11 3",
               {bus.render_ack, bus.buf_sel_display}, bus.dropped_frames);
    end
    bus.render_done = 1'b0;
    bus.enable      = 1'b0;
    repeat (3) tick();
    checks++;
    if ({bus.render_busy, bus.frame_tick, bus.buf_sel_display} !== 3'b001) begin
      errors++;
      $display("FAIL overrun_idle: busy/tick/disp=%b expected 001",
               {bus.render_busy, bus.frame_tick, bus.buf_sel_display});
    end
  endtask

  task automatic test_coincident();
    do_reset();
    bus.render_done = 1'b1;
    repeat (3) begin
      tick();
      checks++;
      if (bus.render_busy !== 1'b0 || bus.render_ack !== 1'b0) begin
        errors++;
        $display("FAIL done_in_idle: busy=%b ack=%b expected 0 0", bus.render_busy, bus.render_ack);
      end
    end
    pulse_nf();
    checks++;
    if (bus.frame_tick !== 1'b1) begin
      errors++;
      $display("FAIL violation_tick: got %b expected 1", bus.frame_tick);
    end
    tick();
    checks++;
    if (bus.render_start !== 1'b1) begin
      errors++;
      $display("FAIL violation_start: got %b expected 1", bus.render_start);
    end
    bus.render_done = 1'b0;
    repeat ($urandom_range(3, 12)) tick();
    bus.render_done = 1'b1;
    bus.new_frame   = 1'b1;
    tick();
    bus.new_frame   = 1'b0;
    checks++;
    if ({bus.render_ack, bus.buf_sel_display} !== 2'b11 || bus.dropped_frames !== CW'(0)) begin
      errors++;
      $display("FAIL coincident_swap: ack/disp=%b drops=%0d expected 11 0",
               {bus.render_ack, bus.buf_sel_display}, bus.dropped_frames);
    end
  endtask

  task automatic test_enable_off();
    do_reset();
    start_render();
    bus.enable = 1'b0;
    repeat (5) tick();
    bus.render_done = 1'b1;
    repeat (3) tick();
    pulse_nf();
    checks++;
    if ({bus.render_ack, bus.buf_sel_display} !== 2'b11) begin
      errors++;
      $display("FAIL disabled_swap: ack/disp=%b expected 11", {bus.render_ack, bus.buf_sel_display});
    end
    bus.render_done = 1'b0;
    tick();
    tick();
    checks++;
    if (bus.render_busy !== 1'b0 || bus.frame_tick !== 1'b0) begin
      errors++;
      $display("FAIL disabled_idle: busy=%b tick=%b expected 0 0", bus.render_busy, bus.frame_tick);
    end
    for (int k = 0; k < 4; k++) begin
      pulse_nf();
      checks++;
      if (bus.frame_tick !== 1'b0 || bus.render_busy !== 1'b0) begin
        errors++;
        $display("FAIL disabled_ignore_nf: tick=%b busy=%b expected 0 0", bus.frame_tick, bus.render_busy);
      end
      repeat (3) tick();
    end
    bus.enable = 1'b1;
    pulse_nf();
    checks++;
    if (bus.frame_tick !== 1'b1) begin
      errors++;
      $display("FAIL reenable_tick: got %b expected 1", bus.frame_tick);
    end
  endtask

  task automatic test_saturation();
    do_reset();
`ifdef FRAME_SCHED_WATCHDOG_EN
    repeat (2) begin
      start_render();
      repeat (TO) begin
        repeat (2) tick();
        pulse_nf();
      end
      tick();
    end
`else
    start_render();
    repeat (10) begin
      repeat (2) tick();
      pulse_nf();
    end
`endif
    checks++;
    if (bus.dropped_frames !== CW'(MAXD)) begin
      errors++;
      $display("FAIL drop_saturate: got %0d expected %0d", bus.dropped_frames, MAXD);
    end
  endtask

  task automatic test_reset_mid_render();
    do_reset();
    start_render();
    bus.render_done = 1'b1;
    pulse_nf();
    bus.render_done = 1'b0;
    repeat (4) tick();
    bus.render_done = 1'b1;
    repeat (3) tick();
    Reset_n       = 1'b0;
    bus.new_frame = 1'b1;
    tick();
    checks++;
    if ({bus.render_ack, bus.render_busy, bus.buf_sel_display, bus.buf_sel_render} !== 4'b0001) begin
      errors++;
      $display("FAIL reset_mid_render: ack/busy/disp/rend=%b expected 0001",
               {bus.render_ack, bus.render_busy, bus.buf_sel_display, bus.buf_sel_render});
    end
    Reset_n         = 1'b1;
    bus.new_frame   = 1'b0;
    bus.render_done = 1'b0;
    tick();
    checks++;
    if ({bus.render_ack, bus.render_busy, bus.buf_sel_display} !== 3'b000) begin
      errors++;
      $display("FAIL after_reset_no_ack: ack/busy/disp=%b expected 000",
               {bus.render_ack, bus.render_busy, bus.buf_sel_display});
    end
  endtask

`ifdef FRAME_SCHED_WATCHDOG_EN
  task automatic test_watchdog();
    do_reset();
    start_render();
    for (int k = 1; k <= TO; k++) begin
      repeat ($urandom_range(2, 10)) tick();
      pulse_nf();
      checks++;
      if (k < TO) begin
        if ({bus.timeout, bus.render_ack, bus.render_busy} !== 3'b001 || bus.dropped_frames !== CW'(k)) begin
          errors++;
          $display("FAIL wd_pending: to/ack/busy=%b drops=%0d expected 001 %0d",
                   {bus.timeout, bus.render_ack, bus.render_busy}, bus.dropped_frames, k);
        end
      end else begin
        if ({bus.timeout, bus.render_ack, bus.render_busy, bus.buf_sel_display} !== 4'b1100 ||
            bus.dropped_frames !== CW'(TO)) begin
          errors++;
          $display("FAIL wd_fire: to/ack/busy/disp=%b drops=%0d expected 1100 %0d",
                   {bus.timeout, bus.render_ack, bus.render_busy, bus.buf_sel_display},
                   bus.dropped_frames, TO);
        end
      end
    end
    tick();
    checks++;
    if ({bus.timeout, bus.render_ack, bus.render_busy} !== 3'b100) begin
      errors++;
      $display("FAIL wd_sticky: to/ack/busy=%b expected 100", {bus.timeout, bus.render_ack, bus.render_busy});
    end
    pulse_nf();
    checks++;
    if (bus.frame_tick !== 1'b1) begin
      errors++;
      $display("FAIL wd_idle_restart: tick=%b expected 1", bus.frame_tick);
    end
    Reset_n = 1'b0;
    tick();
    Reset_n = 1'b1;
    checks++;
    if (bus.timeout !== 1'b0) begin
      errors++;
      $display("FAIL wd_reset_clear: got %b expected 0", bus.timeout);
    end
  endtask
`endif

  task automatic test_random(input int nrend);
    int         nfs[$];
    int         t, tk, st, dn, sw, ak, d, len, cnt, en_off;
    bit         disp;
    logic [6:0] obs, expv;
    for (int i = 0; i < MAXC; i++) begin
      nf_b[i] = 0; dn_b[i] = 0; en_b[i] = 1; e_tick[i] = 0; e_start[i] = 0;
      e_ack[i] = 0; e_busy[i] = 0; drop_ev[i] = 0; tog[i] = 0;
    end
    t = int'($urandom_range(3, 12));
    while (t < MAXC - 100) begin
      nfs.push_back(t);
      nf_b[t] = 1;
      t += int'($urandom_range(15, 70));
    end
    // Each render: tick after the triggering frame start, start next cycle, done after a random
    // duration, swap one cycle after the first frame start at/after done.
    tk  = nfs[0] + 1;
    len = 0;
    for (int r = 0; r < nrend; r++) begin
      st = tk + 1;
      e_tick[tk]  = 1;
      e_start[st] = 1;
      dn = st + int'($urandom_range(1, DUR_MAX));
      sw = -1;
      foreach (nfs[i]) begin
        if (nfs[i] > st && nfs[i] < dn) drop_ev[nfs[i] + 1] = 1;
        if (sw < 0 && nfs[i] >= dn) sw = nfs[i];
      end
      ak = sw + 1;
      e_ack[ak] = 1;
      tog[ak]   = 1;
      for (int c = tk; c < ak; c++) e_busy[c] = 1;
      d = int'($urandom_range(0, 3));
      for (int c = dn; c <= ak + d; c++) dn_b[c] = 1;
      tk  = ak + d + 2;
      len = tk + 40;
      if (r == nrend - 1) begin
        en_off = st + 1 + int'($urandom_range(0, ak - st - 1));
        for (int c = en_off; c < MAXC; c++) en_b[c] = 0;
      end
    end
    cnt  = 0;
    disp = 0;
    for (int c = 0; c < len; c++) begin
      if (drop_ev[c] && cnt < MAXD) cnt++;
      if (tog[c]) disp = ~disp;
      e_drop[c] = cnt;
      e_disp[c] = disp;
    end
    do_reset();
    for (int c = 0; c < len; c++) begin
      obs  = {bus.frame_tick, bus.render_start, bus.render_ack, bus.render_busy,
              bus.buf_sel_display, bus.buf_sel_render, bus.timeout};
      expv = {e_tick[c], e_start[c], e_ack[c], e_busy[c], e_disp[c], ~e_disp[c], 1'b0};
      checks++;
      if (obs !== expv || bus.dropped_frames !== CW'(e_drop[c])) begin
        errors++;
        $display("FAIL random_cycle_%0d: tick/start/ack/busy/disp/rend/to=%b drops=%0d expected %b %0d",
                 c, obs, bus.dropped_frames, expv, e_drop[c]);
      end
      bus.new_frame   = nf_b[c];
      bus.render_done = dn_b[c];
      bus.enable      = en_b[c];
      tick();
    end
    bus.new_frame   = 1'b0;
    bus.render_done = 1'b0;
  endtask

  initial begin
    #600000;
    $display("FAIL global_timeout: simulation exceeded its time budget");
    $fatal(1, "time budget exceeded");
  end

  initial begin
    Reset_n         = 1'b0;
    bus.enable      = 1'b0;
    bus.new_frame   = 1'b0;
    bus.render_done = 1'b0;
    test_reset();
    test_first_frame();
    test_overrun();
    test_coincident();
    test_enable_off();
    test_saturation();
    test_reset_mid_render();
`ifdef FRAME_SCHED_WATCHDOG_EN
    test_watchdog();
`endif
    test_random(6);
    test_random(8);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
